// File: rtl/fx_pkg.sv
// Shared fixed-point helpers: divider FSM states, saturation limits, numerator width.
package fx_pkg;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} fx_state_e;

    // Numerator width: dividend bits plus the divisor's fractional pre-shift.
    function automatic int unsigned num_width(input int unsigned dw, input int unsigned frac);
        return dw + frac;
    endfunction

    // Largest positive value of a w-bit signed number.
    function automatic logic [63:0] sat_pos(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Magnitude of the most negative w-bit signed number.
    function automatic logic [63:0] sat_neg_mag(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fx_sat.sv
// Sign-magnitude to two's complement with saturation; ovf flags a clamped result.
module fx_sat
    import fx_pkg::*;
#(
    parameter int unsigned MAG_W = 33,
    parameter int unsigned OUT_W = 32
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             neg,
    output logic [OUT_W-1:0] val,
    output logic             ovf
);

    localparam logic [MAG_W-1:0] PosLim = MAG_W'(sat_pos(OUT_W));
    localparam logic [MAG_W-1:0] NegLim = MAG_W'(sat_neg_mag(OUT_W));

    logic [MAG_W-1:0] mag_neg;
    assign mag_neg = -mag;

    always_comb begin
        ovf = 1'b0;
        val = OUT_W'(mag);
        if (neg) begin
            if (mag > NegLim) begin
                ovf = 1'b1;
                val = OUT_W'(NegLim);
            end else begin
                val = OUT_W'(mag_neg);
            end
        end else if (mag > PosLim) begin
            ovf = 1'b1;
            val = OUT_W'(PosLim);
        end
    end

endmodule

// File: rtl/div_sfx_ufx.sv
// Iterative signed / unsigned fixed-point divider, one quotient bit per cycle.
// Define DIV_SFX_UFX_ROUND_EN to round half away from zero instead of truncating.
module div_sfx_ufx
    import fx_pkg::*;
#(
    parameter int unsigned DW_A   = 32,
    parameter int unsigned DW_B   = 8,
    parameter int unsigned FRAC_B = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_A-1:0] a,
    input  logic [DW_B-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_A-1:0] q,
    output logic            ovf,
    output logic            dz
);

    localparam int unsigned N  = num_width(DW_A, FRAC_B);
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned RW = DW_B + 1;

    fx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    num_q, num_d;
    logic [N-1:0]    quo_q, quo_d;
    logic [DW_B-1:0] rem_q, rem_d;
    logic [DW_B-1:0] b_q, b_d;
    logic            neg_q, neg_d;
    logic            zdiv_q, zdiv_d;
    logic [DW_A-1:0] q_q, q_d;
    logic            ovf_q, ovf_d;
    logic            dz_q, dz_d;

    logic [DW_A-1:0] abs_a;
    logic [RW-1:0]   rem_sh;
    logic            ge;
    logic [DW_B-1:0] rem_nx;
    logic [N-1:0]    quo_nx;
    logic            rnd_inc;
    logic [N:0]      mag;
    logic [DW_A-1:0] sat_val;
    logic            sat_ovf;

    assign abs_a  = a[DW_A-1] ? -a : a;
    assign rem_sh = {rem_q, num_q[N-1]};
    assign ge     = rem_sh >= {1'b0, b_q};
    // Restored remainder is always below b, so it fits back into DW_B bits.
    assign rem_nx = ge ? DW_B'(rem_sh - {1'b0, b_q}) : DW_B'(rem_sh);
    assign quo_nx = (quo_q << 1) | N'(ge);

`ifdef DIV_SFX_UFX_ROUND_EN
    assign rnd_inc = {rem_nx, 1'b0} >= {1'b0, b_q};
`else
    assign rnd_inc = 1'b0;
`endif

    assign mag = {1'b0, quo_nx} + (N + 1)'(rnd_inc);

    fx_sat #(
        .MAG_W(N + 1),
        .OUT_W(DW_A)
    ) u_sat (
        .mag(mag),
        .neg(neg_q),
        .val(sat_val),
        .ovf(sat_ovf)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        b_d     = b_q;
        neg_d   = neg_q;
        zdiv_d  = zdiv_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StCalc;
                    cnt_d   = CW'(N);
                    num_d   = N'(abs_a) << FRAC_B;
                    quo_d   = '0;
                    rem_d   = '0;
                    b_d     = b;
                    neg_d   = a[DW_A-1];
                    zdiv_d  = (b == '0);
                end
            end
            StCalc: begin
                num_d = num_q << 1;
                quo_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = StDone;
                    dz_d    = zdiv_q;
                    if (zdiv_q) begin
                        q_d   = neg_q ? DW_A'(sat_neg_mag(DW_A)) : DW_A'(sat_pos(DW_A));
                        ovf_d = 1'b0;
                    end else begin
                        q_d   = sat_val;
                        ovf_d = sat_ovf;
                    end
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            num_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            zdiv_q  <= 1'b0;
            q_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            zdiv_q  <= zdiv_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign q         = q_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_div_sfx_ufx.sv
// Scoreboard bench for div_sfx_ufx: default build (FRAC_B=0) plus a FRAC_B=4 instance.
module tb_div_sfx_ufx;

    localparam int N0 = 32;
    localparam int N4 = 36;
`ifdef DIV_SFX_UFX_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid0, in_ready0, out_valid0, out_ready0, ovf0, dz0;
    logic [31:0] a0, q0;
    logic [7:0]  b0;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, ovf4, dz4;
    logic [31:0] a4, q4;
    logic [7:0]  b4;

    div_sfx_ufx #(.DW_A(32), .DW_B(8), .FRAC_B(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0), .a(a0), .b(b0),
        .out_valid(out_valid0), .out_ready(out_ready0), .q(q0), .ovf(ovf0), .dz(dz0)
    );

    div_sfx_ufx #(.DW_A(32), .DW_B(8), .FRAC_B(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .q(q4), .ovf(ovf4), .dz(dz4)
    );

    typedef struct {
        logic [31:0] q;
        logic        ovf;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb4[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // Monitors: latency on the first out_valid cycle, data on the handshake.
    logic ovp0 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid0 && !ovp0) begin
            if (sb0.size() == 0) fail_now("spurious_out_valid0");
            else chk("latency0", 64'(cyc - sb0[0].acc), 64'(N0));
        end
        if (out_valid0 && out_ready0 && sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("q0", 64'(q0), 64'(e.q));
            chk("ovf0", 64'(ovf0), 64'(e.ovf));
            chk("dz0", 64'(dz0), 64'(e.dz));
        end
        ovp0 = out_valid0;
    end

    logic ovp4 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid4 && !ovp4) begin
            if (sb4.size() == 0) fail_now("spurious_out_valid4");
            else chk("latency4", 64'(cyc - sb4[0].acc), 64'(N4));
        end
        if (out_valid4 && out_ready4 && sb4.size() > 0) begin
            e = sb4.pop_front();
            chk("q4", 64'(q4), 64'(e.q));
            chk("ovf4", 64'(ovf4), 64'(e.ovf));
            chk("dz4", 64'(dz4), 64'(e.dz));
        end
        ovp4 = out_valid4;
    end

    task automatic send0(input logic [31:0] a, input logic [7:0] b, input logic [31:0] eq,
                         input logic eo, input logic ed, input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) begin
            fail_now("accept0_timeout");
        end else begin
            a0 = a;
            b0 = b;
            in_valid0 = 1'b1;
            if (push) sb0.push_back('{eq, eo, ed, cyc + 1});
            @(negedge clk);
            in_valid0 = 1'b0;
        end
    endtask

    task automatic send4(input logic [31:0] a, input logic [7:0] b, input logic [31:0] eq,
                         input logic eo, input logic ed);
        int n = 0;
        @(negedge clk);
        while (!in_ready4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready4) begin
            fail_now("accept4_timeout");
        end else begin
            a4 = a;
            b4 = b;
            in_valid4 = 1'b1;
            sb4.push_back('{eq, eo, ed, cyc + 1});
            @(negedge clk);
            in_valid4 = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb0.size() > 0 || sb4.size() > 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb0.size() > 0 || sb4.size() > 0) fail_now("drain_timeout");
    endtask

    initial begin
        logic [31:0] hold_q;
        bit          seen;
        int          n;
        in_valid0 = 1'b0; a0 = '0; b0 = '0; out_ready0 = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;

        #3;
        chk("rst_in_ready", 64'(in_ready0), 64'd1);
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_q", 64'(q0), 64'd0);
        chk("rst_ovf", 64'(ovf0), 64'd0);
        chk("rst_dz", 64'(dz0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send0(-32'sd200, 8'd200, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        send0(32'd1000, 8'd7, RND ? 32'd143 : 32'd142, 1'b0, 1'b0, 1'b1);
        send0(-32'sd1000, 8'd7, RND ? -32'sd143 : -32'sd142, 1'b0, 1'b0, 1'b1);
        send0(32'd5, 8'd0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        send0(-32'sd5, 8'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        send0(32'h8000_0000, 8'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        send0(32'h7FFF_FFFF, 8'd255, 32'd8421504, 1'b0, 1'b0, 1'b1);
        send0(32'd7, 8'd2, RND ? 32'd4 : 32'd3, 1'b0, 1'b0, 1'b1);
        send0(-32'sd7, 8'd2, RND ? -32'sd4 : -32'sd3, 1'b0, 1'b0, 1'b1);
        send0(32'd100, 8'd3, 32'd33, 1'b0, 1'b0, 1'b1);
        send0(32'd0, 8'd5, 32'd0, 1'b0, 1'b0, 1'b1);

        send4(32'd100, 8'd32, 32'd50, 1'b0, 1'b0);
        send4(32'h8000_0000, 8'd1, 32'h8000_0000, 1'b1, 1'b0);
        send4(32'h7FFF_FFFF, 8'd1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        send4(32'd3, 8'd2, 32'd24, 1'b0, 1'b0);
        send4(-32'sd5, 8'd3, RND ? -32'sd27 : -32'sd26, 1'b0, 1'b0);
        drain();

        // Back-pressure: result held while out_ready is low.
        out_ready0 = 1'b0;
        hold_q = RND ? 32'd143 : 32'd142;
        send0(32'd1000, 8'd7, hold_q, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!out_valid0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid0) fail_now("bp_out_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_q_held", 64'(q0), 64'(hold_q));
            chk("bp_out_valid_held", 64'(out_valid0), 64'd1);
            chk("bp_in_ready_low", 64'(in_ready0), 64'd0);
        end
        @(posedge clk);
        #1 out_ready0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", 64'(in_ready0), 64'd1);
        chk("bp_idle_out_valid", 64'(out_valid0), 64'd0);
        a0 = 32'd7;
        b0 = 8'd2;
        in_valid0 = 1'b1;
        sb0.push_back('{RND ? 32'd4 : 32'd3, 1'b0, 1'b0, cyc + 1});
        @(negedge clk);
        in_valid0 = 1'b0;
        drain();

        // Asynchronous reset mid-calculation discards the result.
        send0(32'd1000, 8'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready0), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid0), 64'd0);
        chk("mid_rst_q", 64'(q0), 64'd0);
        chk("mid_rst_ovf", 64'(ovf0), 64'd0);
        chk("mid_rst_dz", 64'(dz0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (N0 + 10) begin
            @(negedge clk);
            if (out_valid0) seen = 1'b1;
        end
        chk("no_out_valid_after_reset", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
